// File: rtl/b_fetch_unit.sv
// b_fetch_unit
// Instruction fetch stage between the program counter and decode.
// Issues word-aligned fetch requests over a valid/ready channel, accepts
// in-order responses, buffers {pc, instruction} pairs in a small FIFO and
// hands them to decode over a valid/ready handshake. A redirect flushes the
// FIFO and drops every response still in flight.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   redirect_valid/redirect_pc  jump/branch target (bits [1:0] ignored)
//   mem_req_valid/ready/addr    fetch request channel
//   mem_rsp_valid/data          in-order fetch responses
//   inst_valid/ready/data/pc    FIFO head towards decode
module b_fetch_unit #(
   parameter int unsigned      width    = 32,
   parameter int unsigned      depth    = 4,
   parameter logic [width-1:0] reset_pc = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect_valid,
   input  logic [width-1:0] redirect_pc,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [width-1:0] mem_req_addr,
   input  logic             mem_rsp_valid,
   input  logic [width-1:0] mem_rsp_data,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [width-1:0] inst_data,
   output logic [width-1:0] inst_pc
);

   localparam int unsigned aw = $clog2(depth);
   localparam int unsigned cw = aw + 1;
   localparam logic [cw:0] depth_c = (cw + 1)'(depth);

   logic [width-1:0] fetch_pc;
   logic [width-1:0] rsp_pc;
   logic [cw-1:0]    outstanding;
   logic [cw-1:0]    discard;
   logic [cw-1:0]    count;
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [width-1:0] fifo_pc   [depth];
   logic [width-1:0] fifo_data [depth];

   logic [cw:0]      credit_used;
   logic [width-1:0] redirect_aligned;
   logic             req_fire;
   logic             rsp_fire;
   logic             push;
   logic             pop;

   always_comb begin
      redirect_aligned = redirect_pc & ~width'(3);
      // Buffered entries plus in-flight fetches may never exceed the FIFO
      // size, so every accepted response is guaranteed a free slot.
      credit_used   = {1'b0, count} + {1'b0, outstanding};
      mem_req_valid = !reset && !redirect_valid && (credit_used < depth_c);
      mem_req_addr  = fetch_pc;
      req_fire      = mem_req_valid && mem_req_ready;
      rsp_fire      = mem_rsp_valid && (outstanding != '0);
      push          = rsp_fire && (discard == '0) && !redirect_valid;
      inst_valid    = (count != '0);
      inst_data     = fifo_data[rd_ptr];
      inst_pc       = fifo_pc[rd_ptr];
      pop           = inst_valid && inst_ready && !redirect_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= reset_pc;
         rsp_pc      <= reset_pc;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         for (int unsigned i = 0; i < depth; i++) begin
            fifo_pc[i]   <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         // req_fire is already gated off during a redirect.
         outstanding <= outstanding + cw'(req_fire) - cw'(rsp_fire);
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            // Every fetch still in flight after this cycle belongs to the
            // old path; a response landing this cycle is dropped here.
            discard  <= outstanding - cw'(rsp_fire);
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + width'(4);
            if (rsp_fire && (discard != '0))
               discard <= discard - cw'(1);
            if (push) begin
               fifo_pc[wr_ptr]   <= rsp_pc;
               fifo_data[wr_ptr] <= mem_rsp_data;
               wr_ptr            <= wr_ptr + aw'(1);
               rsp_pc            <= rsp_pc + width'(4);
            end
            if (pop)
               rd_ptr <= rd_ptr + aw'(1);
            count <= count + cw'(push) - cw'(pop);
         end
      end
   end

endmodule
